// File: rtl/alu_issue_stage.sv
// Issue stage for the 4-function ALU: command FIFO, combinational ALU drive from
// the FIFO head, registered response with valid/ready, and result chaining.
module alu_issue_stage #(
  parameter int unsigned W     = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic [1:0]   cmd_fn,
  input  logic         cmd_chain,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_fn,
  input  logic [W-1:0] alu_result,
  input  logic         alu_n,
  input  logic         alu_z,
  input  logic         alu_v,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic         rsp_n,
  output logic         rsp_z,
  output logic         rsp_v,
  output logic         busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   fn;
    logic         chain;
  } cmd_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [W-1:0]  prev;
  logic          empty;
  logic          push;
  logic          issue;

  assign empty     = (count == '0);
  assign cmd_ready = (count != CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign issue     = !empty && (!rsp_valid || rsp_ready);
  assign busy      = !empty || rsp_valid;
  assign head      = mem[rd_ptr];

  // ALU operands come straight from the FIFO head; chained ops take the last result.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_fn = '0;
    if (!empty) begin
      alu_a  = head.chain ? prev : head.a;
      alu_b  = head.b;
      alu_fn = head.fn;
    end
  end

  // Storage array carries no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, fn: cmd_fn, chain: cmd_chain};
    end
  end

  // Pointers and occupancy; clr drops everything including this cycle's push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (issue) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, issue})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Response register and chain register; data holds while a response drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_n      <= 1'b0;
      rsp_z      <= 1'b0;
      rsp_v      <= 1'b0;
      prev       <= '0;
    end else if (clr) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_n      <= 1'b0;
      rsp_z      <= 1'b0;
      rsp_v      <= 1'b0;
      prev       <= '0;
    end else if (issue) begin
      rsp_valid  <= 1'b1;
      rsp_result <= alu_result;
      rsp_n      <= alu_n;
      rsp_z      <= alu_z;
      rsp_v      <= alu_v;
      prev       <= alu_result;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule
